// File: rtl/aes_key_expansion.sv
// ============================================================================
// Module   : aes_key_expansion
// Purpose  : AES-128 round-key generator. Streams the 11 round keys forward
//            directly or, for decryption, expands into a buffer then streams
//            them in reverse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_key_expansion #(
  parameter int DATA_W = 128,
  parameter int NR     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid_in,
  input  logic [DATA_W-1:0] key_in,
  input  logic              mode_dec,
  output logic              key_valid,
  output logic [DATA_W-1:0] round_key,
  output logic [3:0]        round_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_FWD    = 2'd1;
  localparam logic [1:0] c_EXPAND = 2'd2;
  localparam logic [1:0] c_REV    = 2'd3;
  localparam logic [3:0] c_LAST   = 4'(NR);

  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return c_SBOX[(255 - int'(b))*8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_work;
  logic [DATA_W-1:0] r_key;
  logic [DATA_W-1:0] r_buf [0:NR];

  logic [31:0]       w_rot;
  logic [31:0]       w_sub;
  logic [31:0]       w_t;
  logic [31:0]       w_n0, w_n1, w_n2, w_n3;
  logic [DATA_W-1:0] w_next;

  // r_work always holds key number r_cnt, so its successor uses Rcon[r_cnt+1]
  assign w_rot = {r_work[23:0], r_work[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign w_sub[8*g +: 8] = sbox(w_rot[8*g +: 8]);
  end

  assign w_t    = w_sub ^ {rcon(r_cnt + 4'd1), 24'h0};
  assign w_n0   = r_work[127:96] ^ w_t;
  assign w_n1   = r_work[95:64]  ^ w_n0;
  assign w_n2   = r_work[63:32]  ^ w_n1;
  assign w_n3   = r_work[31:0]   ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (key_valid_in) w_state_nxt = mode_dec ? c_EXPAND : c_FWD;
      c_FWD:    if (r_cnt == c_LAST) w_state_nxt = c_IDLE;
      c_EXPAND: if (r_cnt == c_LAST) w_state_nxt = c_REV;
      c_REV:    if (r_cnt == 4'd0) w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    key_valid = (r_state == c_FWD) || (r_state == c_REV);
    busy      = (r_state != c_IDLE);
    done      = ((r_state == c_FWD) && (r_cnt == c_LAST)) ||
                ((r_state == c_REV) && (r_cnt == 4'd0));
    round_idx = key_valid ? r_cnt : 4'd0;
    round_key = r_key;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= 4'd0;
      r_work <= '0;
      r_key  <= '0;
      for (int i = 0; i <= NR; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (key_valid_in) begin
            r_work <= key_in;
            r_cnt  <= 4'd0;
            if (!mode_dec) r_key <= key_in;
          end
        end
        c_FWD: begin
          if (r_cnt == c_LAST) begin
            r_cnt <= 4'd0;
          end else begin
            r_work <= w_next;
            r_key  <= w_next;
            r_cnt  <= r_cnt + 4'd1;
          end
        end
        c_EXPAND: begin
          r_buf[r_cnt] <= r_work;
          // last key bypasses the buffer so the reverse stream starts at once
          if (r_cnt == c_LAST) begin
            r_key <= r_work;
          end else begin
            r_work <= w_next;
            r_cnt  <= r_cnt + 4'd1;
          end
        end
        c_REV: begin
          if (r_cnt != 4'd0) begin
            r_key <= r_buf[r_cnt - 4'd1];
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_cnt <= 4'd0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expansion.sv
// ============================================================================
// Module   : tb_aes_key_expansion
// Purpose  : Randomised and directed bench for aes_key_expansion against a
//            word-array FIPS 197 key-expansion model with a computed S-box.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_key_expansion;

  localparam logic [127:0] c_KF  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] c_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] c_Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] c_Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_valid_in = 1'b0;
  logic [127:0] key_in = '0;
  logic         mode_dec = 1'b0;
  logic         key_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  aes_key_expansion #(.DATA_W(128), .NR(10)) dut (
    .clk(clk), .reset(reset), .key_valid_in(key_valid_in), .key_in(key_in),
    .mode_dec(mode_dec), .key_valid(key_valid), .round_key(round_key),
    .round_idx(round_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tstart = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sb [256];

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      y = y >> 1;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [10:0][127:0] model_keys(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [10:0][127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: outputs are a function of cycles elapsed since the accepted start
  logic               m_active = 1'b0;
  int                 m_T = 0;
  logic               m_rev = 1'b0;
  logic [10:0][127:0] m_keys;
  logic [127:0]       m_last = '0;

  always @(negedge clk) begin
    int           k;
    logic         ekv, ebusy, edone;
    logic [3:0]   eidx;
    logic [127:0] ekey;
    if (!reset) begin
      m_active = 1'b0;
      m_last   = '0;
      chk("rst_key_valid", 128'(key_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_round_idx", 128'(round_idx), 128'd0);
      chk("rst_round_key", round_key, 128'd0);
    end else begin
      k = cyc - m_T;
      if (m_active && k >= (m_rev ? 23 : 12)) m_active = 1'b0;
      ekv = 1'b0; ebusy = 1'b0; edone = 1'b0; eidx = 4'd0; ekey = m_last;
      if (m_active) begin
        ebusy = 1'b1;
        if (!m_rev) begin
          ekv = 1'b1; eidx = 4'(k - 1); edone = (k == 11);
        end else if (k >= 12) begin
          ekv = 1'b1; eidx = 4'(22 - k); edone = (k == 22);
        end
        if (ekv) begin
          ekey   = m_keys[eidx];
          m_last = ekey;
        end
      end
      chk("key_valid", 128'(key_valid), 128'(ekv));
      chk("busy", 128'(busy), 128'(ebusy));
      chk("done", 128'(done), 128'(edone));
      chk("round_idx", 128'(round_idx), 128'(eidx));
      chk("round_key", round_key, ekey);
      if (!m_active && key_valid_in) begin
        m_active = 1'b1;
        m_T      = cyc;
        m_rev    = mode_dec;
        m_keys   = model_keys(key_in);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [127:0] k, input logic m);
    key_valid_in = 1'b1;
    key_in       = k;
    mode_dec     = m;
    tstart       = cyc;
    @(posedge clk);
    #1;
    key_valid_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0][127:0] pk;
    logic [127:0] rk;
    logic         m;
    int           n;

    build_sbox();
    chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
    pk = model_keys(c_KF);
    chk("model_fips_idx1", pk[1], c_K1);
    chk("model_fips_idx10", pk[10], c_K10);
    pk = model_keys('0);
    chk("model_zero_idx1", pk[1], c_Z1);
    chk("model_zero_idx10", pk[10], c_Z10);

    step(3);
    reset = 1'b1;
    step(2);

    // forward run of the FIPS key
    start(c_KF, 1'b0);
    chk("fwd_idx0", round_key, c_KF);
    step(1);
    chk("fwd_idx1", round_key, c_K1);
    step(9);
    chk("fwd_idx10", round_key, c_K10);
    chk("fwd_done", 128'(done), 128'd1);
    step(1);

    // reverse run issued the cycle IDLE is re-entered
    start(c_KF, 1'b1);
    step(10);
    chk("rev_quiet_T11", 128'(key_valid), 128'd0);
    step(1);
    chk("rev_idx10", round_key, c_K10);
    chk("rev_idx10_n", 128'(round_idx), 128'd10);
    step(9);
    chk("rev_idx1", round_key, c_K1);
    step(1);
    chk("rev_idx0", round_key, c_KF);
    chk("rev_done", 128'(done), 128'd1);
    step(1);

    start('0, 1'b0);
    step(1);
    chk("zero_idx1", round_key, c_Z1);
    step(9);
    chk("zero_idx10", round_key, c_Z10);
    step(1);

    // stray start while busy must be ignored
    start(c_KF, 1'b0);
    step(4);
    key_valid_in = 1'b1;
    key_in       = {$urandom, $urandom, $urandom, $urandom};
    mode_dec     = 1'b1;
    step(1);
    key_valid_in = 1'b0;
    step(5);
    chk("ignore_idx10", round_key, c_K10);
    chk("ignore_done", 128'(done), 128'd1);
    step(1);
    rk = {$urandom, $urandom, $urandom, $urandom};
    start(rk, 1'b0);
    chk("restart_idx0", round_key, rk);
    chk("restart_valid", 128'(key_valid), 128'd1);
    step(11);

    // asynchronous reset in the middle of a reverse run
    start({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    step(5);
    reset = 1'b0;
    #1;
    chk("abort_key_valid", 128'(key_valid), 128'd0);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_round_key", round_key, 128'd0);
    step(2);
    reset = 1'b1;
    step(15);

    for (int it = 0; it < 40; it++) begin
      m  = 1'($urandom % 2);
      rk = {$urandom, $urandom, $urandom, $urandom};
      start(rk, m);
      n = m ? 22 : 11;
      for (int c = 0; c < n; c++) begin
        key_valid_in = ($urandom % 6 == 0);
        key_in       = {$urandom, $urandom, $urandom, $urandom};
        mode_dec     = 1'($urandom % 2);
        step(1);
      end
      key_valid_in = 1'b0;
      step(int'($urandom % 3));
    end

    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Generates the eleven AES-128 round keys from a 128-bit cipher key, per FIPS 197 KeyExpansion.
- Drives the round-key side of the AddRoundKey stage, which consumes round_key and key_valid.
- Encrypt mode streams keys in order, round 0 to 10, one per cycle.
- Decrypt mode expands into an internal buffer first, then streams keys in reverse, round 10 to 0, for the inverse cipher.

Parameters:
- DATA_W, 128, key and round-key width. Only 128 is supported.
- NR, 10, number of rounds. NR+1 keys are produced.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- key_valid_in  input  1  one-cycle start strobe; key_in and mode_dec are sampled on this cycle
- key_in  input  DATA_W  cipher key; [127:96] is w0, [31:0] is w3
- mode_dec  input  1  0 = forward order, 1 = reverse order
- key_valid  output  1  round_key and round_idx are valid this cycle
- round_key  output  DATA_W  current round key
- round_idx  output  4  index of the round key currently presented (0..10)
- busy  output  1  high from the cycle after the start is accepted until done
- done  output  1  one-cycle pulse coincident with the last valid key

Behaviour:
- Reset (async, active-low):
  - all outputs go to 0; FSM goes to IDLE; key buffer and working key are cleared.
  - Reset asserted mid-operation aborts immediately; no further key_valid after release.
- FSM states: IDLE, FWD, EXPAND, REV.
- IDLE:
  - key_valid_in=1 loads the working key from key_in and latches mode_dec.
  - Goes to FWD if mode_dec=0, else EXPAND. busy=1 from the next cycle.
- key_valid_in while busy=1 is ignored; it does not restart and does not corrupt the current sequence.
- Next-key function, with rk = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {Rcon[i],24'h0}
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - SubWord applies the FIPS 197 S-box to each byte (4 parallel instances, purely combinational).
- FWD:
  - Start accepted at cycle T.
  - T+1: key_valid=1, round_idx=0, round_key=key_in.
  - Each following cycle round_idx increments and round_key = next(previous).
  - T+11: round_idx=10, done=1. T+12: back in IDLE with key_valid=0 and busy=0.
  - key_valid stays high for exactly 11 consecutive cycles.
- EXPAND:
  - Cycles T+1..T+11 write keys 0..10 into an 11-entry x 128-bit buffer, indexed by round.
  - key_valid=0 throughout.
- REV:
  - T+12..T+22: key_valid=1, round_idx counts 10 down to 0, round_key = buffer[round_idx].
  - done=1 at T+22. IDLE at T+23.
- Counter boundaries: round counter never wraps beyond 0..10. An idle round_idx holds 0.
- Idle outputs: round_key holds its last value when key_valid=0; consumers must qualify it with key_valid.
- No back-pressure: the consumer must accept one key per cycle while key_valid=1.
- A new start is accepted in the cycle IDLE is re-entered (T+12 fwd, T+23 rev), giving back-to-back operation.

Test Plan:
- Reset then fwd start, key 2b7e151628aed2a6abf7158809cf4f3c:
  - idx0 = same key at T+1.
  - idx1 = a0fafe1788542cb123a339392a6c7605 at T+2.
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at T+11 with done=1.
  - 11 valid cycles total.
- Same key with mode_dec=1:
  - no key_valid for T+1..T+11.
  - T+12: idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - T+21: idx1 = a0fafe17….
  - T+22: idx0 = 2b7e1516…, with done=1.
- All-zero key, fwd: idx1 = 62636363626363636263636362636363; idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- key_valid_in pulsed at T+5 with a different key during a fwd run:
  - the sequence is unchanged and the original key's idx10 appears at T+11.
  - a start at T+12 is accepted and gives idx0 at T+13.
- reset deasserted→asserted at T+6 of a rev run:
  - all outputs are 0 immediately.
  - after release, key_valid stays 0 until a new start is issued.
- Back-to-back: fwd start, then a rev start exactly at T+12 → reversed sequence begins at T+24 with no gap errors.
